scanline_ring_buffer: RTL

//   Parametrised multi-line pixel buffer for the upscaler datapath, built on inferred simple dual-port block RAM.

---
 rtl/scanline_ring_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/scanline_ring_buffer.sv
// Scanline ring buffer: NUM_LINES line slots in a simple dual-port RAM, replayable until released.
// Define SCANLINE_BUF_OUT_REG_EN to add a RAM output register (read latency 3 instead of 2).
module scanline_ring_buffer #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned LINE_LEN  = 1024,
    parameter int unsigned NUM_LINES = 4,
    localparam int unsigned AW = $clog2(LINE_LEN),
    localparam int unsigned SW = $clog2(NUM_LINES),
    localparam int unsigned CW = $clog2(NUM_LINES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_eol,
    output logic              wr_ready,
    input  logic              rd_start,
    input  logic              rd_release,
    output logic              rd_busy,
    output logic [AW:0]       rd_len,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [CW-1:0]     lines_avail,
    output logic              ovf_err
);

    typedef enum logic [0:0] {StIdle, StRun} rd_state_e;

    logic [DATA_W-1:0] mem [NUM_LINES*LINE_LEN];
    logic [AW:0]       len_q [NUM_LINES];

    logic [SW-1:0]     wr_slot_q, rd_slot_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     avail_q;
    logic              ovf_q;
    logic              busy_q;
    rd_state_e         state_q;

    logic              iss_valid_q, iss_last_q;
    logic [SW+AW-1:0]  iss_addr_q;
    logic              ram_valid_q, ram_last_q;
    logic [DATA_W-1:0] ram_data_q;

    logic              have_line, wr_accept, commit, start_ok, release_ok;
    logic [AW:0]       head_len;

    assign have_line  = (avail_q != '0);
    assign wr_ready   = (avail_q < CW'(NUM_LINES));
    assign wr_accept  = wr_valid & wr_ready;
    assign commit     = wr_accept & (wr_eol | (wr_ptr_q == AW'(LINE_LEN - 1)));
    assign start_ok   = rd_start & ~busy_q & have_line;
    // A start in the same cycle takes priority over the release
    assign release_ok = rd_release & ~busy_q & have_line & ~rd_start;
    assign head_len   = len_q[rd_slot_q];

    assign rd_len      = have_line ? head_len : '0;
    assign lines_avail = avail_q;
    assign ovf_err     = ovf_q;
    assign rd_busy     = busy_q;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_slot_q, wr_ptr_q}] <= wr_data;
        end
        if (commit) begin
            len_q[wr_slot_q] <= {1'b0, wr_ptr_q} + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_slot_q <= '0;
            wr_ptr_q  <= '0;
            rd_slot_q <= '0;
            avail_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr_q  <= '0;
                wr_slot_q <= wr_slot_q + SW'(1);
            end else if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (wr_valid && !wr_ready) begin
                ovf_q <= 1'b1;
            end
            if (release_ok) begin
                rd_slot_q <= rd_slot_q + SW'(1);
            end
            if (commit && !release_ok) begin
                avail_q <= avail_q + CW'(1);
            end else if (release_ok && !commit) begin
                avail_q <= avail_q - CW'(1);
            end
        end
    end

    // Read sequencer: registers one address per cycle into the issue stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_addr_q  <= '0;
        end else begin
            iss_valid_q <= 1'b0;
            iss_last_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q  <= StRun;
                        rd_ptr_q <= '0;
                    end
                end
                StRun: begin
                    iss_valid_q <= 1'b1;
                    iss_addr_q  <= {rd_slot_q, rd_ptr_q};
                    rd_ptr_q    <= rd_ptr_q + AW'(1);
                    if (({1'b0, rd_ptr_q} + (AW+1)'(1)) == head_len) begin
                        iss_last_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (rd_valid && rd_last) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_valid_q <= 1'b0;
            ram_last_q  <= 1'b0;
            ram_data_q  <= '0;
        end else begin
            ram_valid_q <= iss_valid_q;
            ram_last_q  <= iss_last_q;
            if (iss_valid_q) begin
                ram_data_q <= mem[iss_addr_q];
            end
        end
    end

`ifdef SCANLINE_BUF_OUT_REG_EN
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= ram_valid_q;
            out_last_q  <= ram_last_q;
            if (ram_valid_q) begin
                out_data_q <= ram_data_q;
            end
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_last  = out_last_q;
    assign rd_data  = out_data_q;
`else
    assign rd_valid = ram_valid_q;
    assign rd_last  = ram_last_q;
    assign rd_data  = ram_data_q;
`endif

endmodule
